uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command controller for the UART debugger. It parses byte frames from the UART receiver into register-bus writes and reads on the `u_reg_*` interface. It then returns a status/response frame to the UART transmitter. It sits between the UART RX/TX byte engines and the core register bus, in the `clk_25mhz` domain.

## Interface
Parameters:
- `MAGIC`, 8'hCC, frame-start byte.
- `CMD_WR`, 8'h06, write command code.
- `CMD_RD`, 8'h86, read command code.
- `RD_TIMEOUT`, 1024, maximum cycles spent waiting for `u_reg_rd_done`; only used when the timeout feature is compiled in.

Ports:
- `clk_25mhz` in 1: single clock.
- `core_reset` in 1: reset, synchronous, active-high.
- `rx_byte` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid.
- `tx_byte` out 8: byte to transmit.
- `tx_valid` out 1: transmit request.
- `tx_ready` in 1: transmitter accepts `tx_byte` when `tx_valid && tx_ready`.
- `u_reg_addr` out 8: register address.
- `u_reg_wr_data` out 32: write data.
- `u_reg_wr_en` out 1: one-cycle write strobe.
- `u_reg_rd_en` out 1: read request, level.
- `u_reg_rd_data` in 32: read data.
- `u_reg_rd_done` in 1: read data valid.
- `busy` out 1: high in every state except HUNT.
- `frame_err` out 1: one-cycle pulse on a bad command or on a byte dropped during EXEC/RESP.

## Operation
- **Frame format:** 7 bytes, sent as MAGIC, CMD, ADDR, D[31:24], D[23:16], D[15:8], D[7:0]. Read frames also carry 4 data bytes; the controller ignores them.
- **States:** HUNT → CMD → ADDR → DATA → EXEC → RESP → HUNT.
  - HUNT: `rx_valid` with `rx_byte==MAGIC` moves to CMD. Any other byte is silently discarded.
  - CMD: latch the command byte. Any value is accepted at this point; validity is checked in DATA.
  - ADDR: latch into `u_reg_addr`.
  - DATA: shift bytes into `u_reg_wr_data` MSB-first, using a 2-bit byte counter 3→0. When the 4th byte arrives, the command is checked:
    - CMD_WR → EXEC with a write.
    - CMD_RD → EXEC with a read.
    - Anything else → RESP with status 8'hE0 and a `frame_err` pulse.
  - EXEC write: `u_reg_wr_en` is high for exactly 1 cycle, then RESP with status 8'hA0.
  - EXEC read: `u_reg_rd_en` is held high until the first cycle in which `u_reg_rd_done==1`. That cycle captures `u_reg_rd_data`, and the next state is RESP with status 8'hA1 followed by the 4 data bytes MSB-first.
  - RESP: present each byte on `tx_byte` with `tx_valid=1` and advance on `tx_valid && tx_ready`. After the last byte, return to HUNT.
- **Dropped bytes:** `rx_valid` in EXEC or RESP drops the byte and pulses `frame_err`. Frames are never queued.
- **Held values:** `u_reg_addr` and `u_reg_wr_data` hold their last values outside DATA/EXEC.

## Timing
- **Reset values:** state=HUNT; `tx_byte`=0; `tx_valid`=0; `u_reg_addr`=0; `u_reg_wr_data`=0; `u_reg_wr_en`=0; `u_reg_rd_en`=0; `busy`=0; `frame_err`=0.
- **Reset mid-frame or mid-read:** return to HUNT on the next edge. `u_reg_rd_en` drops and no response is sent.
- **Byte latency:** each accepted `rx_byte` takes effect on the edge where `rx_valid` is sampled high.
- **Write:** `u_reg_wr_en` asserts in the cycle after the 7th byte is sampled.
- **Read:** `u_reg_rd_en` asserts in the cycle after the 7th byte is sampled. `u_reg_rd_done` is only sampled while `u_reg_rd_en` is high, so a done seen in the first rd_en cycle is valid. `u_reg_rd_en` deasserts in the cycle after done.
- **First response byte:** `tx_valid` rises in the cycle after EXEC completes.
- **TX handshake:** `tx_byte` is stable while `tx_valid && !tx_ready`. With `tx_ready` held high, successive bytes go out back-to-back, 1 per cycle.
- **Strobes:** `u_reg_wr_en` and `u_reg_rd_en` are never high together.

## Configuration
- **`UART_CMD_RD_TIMEOUT_EN` defined:**
  - A counter, `$clog2(RD_TIMEOUT+1)` bits wide, counts cycles while `u_reg_rd_en` is high.
  - When the count reaches `RD_TIMEOUT` with no done, `u_reg_rd_en` drops and the controller goes to RESP with the single status byte 8'hE1.
  - A done arriving in the same cycle as the limit wins, and the normal A1 response is sent.
- **Not defined:** no counter; the read waits indefinitely.

## Structure
- **Package `uart_dbg_pkg`:**
  - state enum `uart_cmd_state_e`
  - status constants: `ST_WR_ACK`=8'hA0, `ST_RD_ACK`=8'hA1, `ST_BAD_CMD`=8'hE0, `ST_RD_TMO`=8'hE1
  - frame length constant 7
- **Sub-module `uart_cmd_resp`:** response serializer. Loads status plus optional 32-bit data and a length of 1 or 5, then drives the `tx_valid`/`tx_ready` handshake.

## Test plan
- **Write:** frame CC 06 A2 DE AD BE EF with `tx_ready`=1 → one `u_reg_wr_en` pulse with addr=A2 and wr_data=DEADBEEF; tx sends A0.
- **Read:** frame CC 86 10 00 00 00 00, with a model returning AAAADDDD and done 1 cycle after rd_en → tx sends A1 AA AA DD DD; rd_en is high for exactly 2 cycles.
- **Resync and bad command:** bytes 55 00 before CC 07 01 00 00 00 00 → junk ignored; tx sends E0; `frame_err` pulses once; no bus strobe.
- **TX backpressure:** `tx_ready` low for 5 cycles during the read response → `tx_byte` holds its value; all 5 bytes are sent in order.
- **Timeout:** macro defined, `RD_TIMEOUT`=16, done never asserted → rd_en is high for 16 cycles; tx sends E1. Macro undefined → the controller stays busy.
- **Reset mid-frame:** `core_reset` pulsed after byte 4; then a full write frame → the new frame executes normally, with no stale data.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debugger command path.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_RESP
    } uart_cmd_state_e;

    localparam logic [7:0] ST_WR_ACK  = 8'hA0;
    localparam logic [7:0] ST_RD_ACK  = 8'hA1;
    localparam logic [7:0] ST_BAD_CMD = 8'hE0;
    localparam logic [7:0] ST_RD_TMO  = 8'hE1;

    localparam int unsigned FRAME_LEN  = 7;
    // MAGIC, CMD and ADDR precede the payload.
    localparam int unsigned DATA_BYTES = FRAME_LEN - 3;

endpackage

// File: rtl/uart_cmd_resp.sv
// Response serializer: loads a status byte plus optional 32-bit data (length 1 or 5)
// and streams the bytes out over the tx_valid/tx_ready handshake.
module uart_cmd_resp (
    input  logic        clk_25mhz,
    input  logic        core_reset,
    input  logic        load,
    input  logic [7:0]  status,
    input  logic [31:0] data,
    input  logic [2:0]  len,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        last
);

    logic [31:0] data_q;
    logic [2:0]  left;

    assign last = tx_valid && tx_ready && (left == 3'd0);

    // NOTE: state registers are updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk_25mhz) begin
        if (core_reset) begin
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
            data_q   <= 32'h0;
            left     <= 3'd0;
        end else if (load) begin
            tx_byte  <= status;
            tx_valid <= 1'b1;
            data_q   <= data;
            left     <= len - 3'd1;
        end else if (tx_valid && tx_ready) begin
            if (left == 3'd0) begin
                tx_valid <= 1'b0;
            end else begin
                tx_byte <= data_q[31:24];
                data_q  <= {data_q[23:0], 8'h00};
                left    <= left - 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART debugger command controller: parses 7-byte frames into register-bus accesses
// and returns a status frame. Define UART_CMD_RD_TIMEOUT_EN to bound read waits.
module uart_cmd_ctrl
    import uart_dbg_pkg::*;
#(
    parameter logic [7:0]  MAGIC      = 8'hCC,
    parameter logic [7:0]  CMD_WR     = 8'h06,
    parameter logic [7:0]  CMD_RD     = 8'h86,
    parameter int unsigned RD_TIMEOUT = 1024
) (
    input  logic        clk_25mhz,
    input  logic        core_reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  u_reg_addr,
    output logic [31:0] u_reg_wr_data,
    output logic        u_reg_wr_en,
    output logic        u_reg_rd_en,
    input  logic [31:0] u_reg_rd_data,
    input  logic        u_reg_rd_done,
    output logic        busy,
    output logic        frame_err
);

    if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
        $error("RD_TIMEOUT must be at least 1");
    end

    uart_cmd_state_e state;
    logic [7:0]      cmd_q;
    logic [1:0]      byte_cnt;

    logic            resp_load;
    logic [7:0]      resp_status;
    logic [2:0]      resp_len;
    logic            resp_last;

`ifdef UART_CMD_RD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
    logic [TW-1:0] rd_cnt;
`endif

    assign busy = (state != S_HUNT);

    // Decides in the current cycle whether a response starts, so tx_valid rises on the same edge.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        resp_load   = 1'b0;
        resp_status = ST_WR_ACK;
        resp_len    = 3'd1;
        unique case (state)
            S_DATA: begin
                if (rx_valid && byte_cnt == 2'd0 && cmd_q != CMD_WR && cmd_q != CMD_RD) begin
                    resp_load   = 1'b1;
                    resp_status = ST_BAD_CMD;
                end
            end
            S_EXEC: begin
                if (u_reg_wr_en) begin
                    resp_load = 1'b1;
                end else if (u_reg_rd_en && u_reg_rd_done) begin
                    resp_load   = 1'b1;
                    resp_status = ST_RD_ACK;
                    resp_len    = 3'd5;
`ifdef UART_CMD_RD_TIMEOUT_EN
                end else if (u_reg_rd_en && rd_cnt == TMO_LAST) begin
                    resp_load   = 1'b1;
                    resp_status = ST_RD_TMO;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (core_reset) begin
            state         <= S_HUNT;
            cmd_q         <= 8'h00;
            byte_cnt      <= 2'd0;
            u_reg_addr    <= 8'h00;
            u_reg_wr_data <= 32'h0;
            u_reg_wr_en   <= 1'b0;
            u_reg_rd_en   <= 1'b0;
            frame_err     <= 1'b0;
`ifdef UART_CMD_RD_TIMEOUT_EN
            rd_cnt        <= '0;
`endif
        end else begin
            u_reg_wr_en <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                S_HUNT: if (rx_valid && rx_byte == MAGIC) state <= S_CMD;
                S_CMD: begin
                    if (rx_valid) begin
                        cmd_q <= rx_byte;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        u_reg_addr <= rx_byte;
                        byte_cnt   <= 2'(DATA_BYTES - 1);
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        u_reg_wr_data <= {u_reg_wr_data[23:0], rx_byte};
                        byte_cnt      <= byte_cnt - 2'd1;
                        if (byte_cnt == 2'd0) begin
                            if (cmd_q == CMD_WR) begin
                                u_reg_wr_en <= 1'b1;
                                state       <= S_EXEC;
                            end else if (cmd_q == CMD_RD) begin
                                u_reg_rd_en <= 1'b1;
                                state       <= S_EXEC;
`ifdef UART_CMD_RD_TIMEOUT_EN
                                rd_cnt      <= '0;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_RESP;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    if (rx_valid) frame_err <= 1'b1;
`ifdef UART_CMD_RD_TIMEOUT_EN
                    if (u_reg_rd_en) rd_cnt <= rd_cnt + 1'b1;
`endif
                    if (resp_load) begin
                        u_reg_rd_en <= 1'b0;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rx_valid) frame_err <= 1'b1;
                    if (resp_last) state <= S_HUNT;
                end
                default: state <= S_HUNT;
            endcase
        end
    end

    uart_cmd_resp u_resp (
        .clk_25mhz  (clk_25mhz),
        .core_reset (core_reset),
        .load       (resp_load),
        .status     (resp_status),
        .data       (u_reg_rd_data),
        .len        (resp_len),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .last       (resp_last)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed cases plus randomized frames against a frame-level model.
module tb_uart_cmd_ctrl;
    import uart_dbg_pkg::*;

    localparam int TMO = 16;
    localparam logic [7:0] MAGIC = 8'hCC;
    localparam logic [7:0] CMD_WR = 8'h06;
    localparam logic [7:0] CMD_RD = 8'h86;
`ifdef UART_CMD_RD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_25mhz = 1'b0;
    logic        core_reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  u_reg_addr;
    logic [31:0] u_reg_wr_data;
    logic        u_reg_wr_en;
    logic        u_reg_rd_en;
    logic [31:0] u_reg_rd_data;
    logic        u_reg_rd_done;
    logic        busy;
    logic        frame_err;

    uart_cmd_ctrl #(.MAGIC(MAGIC), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .RD_TIMEOUT(TMO)) dut (
        .clk_25mhz     (clk_25mhz),
        .core_reset    (core_reset),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .u_reg_addr    (u_reg_addr),
        .u_reg_wr_data (u_reg_wr_data),
        .u_reg_wr_en   (u_reg_wr_en),
        .u_reg_rd_en   (u_reg_rd_en),
        .u_reg_rd_data (u_reg_rd_data),
        .u_reg_rd_done (u_reg_rd_done),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int total = 0;
    int bad = 0;

    // Bus/transmitter environment knobs.
    int          rd_lat;
    logic [31:0] rd_value;
    int          ready_mode;
    int          bp_left;

    // Observations.
    logic [7:0]  txq[$];
    int          wr_cnt, rd_cycles, err_cnt;
    logic [7:0]  wr_addr_seen;
    logic [31:0] wr_data_seen;
    logic        mon_stall;
    logic [7:0]  mon_held;

    // Expectations.
    logic [7:0]  exp_tx[$];
    int          exp_wr, exp_rd, exp_err;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_rd_start, exp_tx_now;

    assign u_reg_rd_data = rd_value;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register-bus read responder and transmitter ready generator.
    initial begin : bus_model
        int k;
        k = 0;
        u_reg_rd_done = 1'b0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_25mhz); #1;
            k = u_reg_rd_en ? k + 1 : 0;
            u_reg_rd_done = u_reg_rd_en && (rd_lat >= 0) && (k == rd_lat + 1);
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (tx_valid && tx_byte == 8'hAA && bp_left > 0) begin
                        tx_ready = 1'b0;
                        bp_left--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        mon_stall = 1'b0;
        mon_held = 8'h00;
        forever begin
            @(negedge clk_25mhz);
            if (core_reset) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("tx_hold_byte", tx_byte, mon_held);
                    check("tx_hold_valid", tx_valid, 1);
                end
                if (u_reg_wr_en || u_reg_rd_en) check("strobe_excl", u_reg_wr_en & u_reg_rd_en, 0);
                if (u_reg_wr_en) begin
                    wr_cnt++;
                    wr_addr_seen = u_reg_addr;
                    wr_data_seen = u_reg_wr_data;
                end
                if (u_reg_rd_en) rd_cycles++;
                if (tx_valid && tx_ready) txq.push_back(tx_byte);
                if (frame_err) err_cnt++;
                mon_stall = tx_valid && !tx_ready;
                mon_held = tx_byte;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_25mhz); #1;
        end
    endtask

    task automatic clear_obs();
        txq.delete();
        wr_cnt = 0;
        rd_cycles = 0;
        err_cnt = 0;
    endtask

    // Frame-level model: what a complete frame should produce on the bus and the TX side.
    task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [31:0] data, input int lat);
        exp_tx.delete();
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        exp_addr = addr; exp_data = data;
        exp_rd_start = (cmd == CMD_RD);
        exp_tx_now = (cmd != CMD_WR && cmd != CMD_RD);
        if (cmd == CMD_WR) begin
            exp_wr = 1;
            exp_tx.push_back(ST_WR_ACK);
        end else if (cmd == CMD_RD) begin
            if (TMO_EN && (lat < 0 || lat >= TMO)) begin
                exp_rd = TMO;
                exp_tx.push_back(ST_RD_TMO);
            end else begin
                exp_rd = lat + 1;
                exp_tx.push_back(ST_RD_ACK);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(rd_value[i*8 +: 8]);
            end
        end else begin
            exp_err = 1;
            exp_tx.push_back(ST_BAD_CMD);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk_25mhz); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int junk, input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [31:0] data, input bit gaps);
        logic [7:0] fr[7];
        logic [7:0] b;
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            if (b == MAGIC) b = 8'h55;
            send_byte(b);
            if (gaps) idle($urandom_range(0, 2));
        end
        fr[0] = MAGIC; fr[1] = cmd; fr[2] = addr;
        for (int i = 0; i < 4; i++) fr[3+i] = data[(3-i)*8 +: 8];
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_byte(fr[i]);
            if (gaps && i < FRAME_LEN - 1) idle($urandom_range(0, 2));
        end
        @(negedge clk_25mhz);
        check("wr_en_latency", u_reg_wr_en, exp_wr);
        check("rd_en_latency", u_reg_rd_en, exp_rd_start);
        check("tx_valid_bad_latency", tx_valid, exp_tx_now);
        @(posedge clk_25mhz); #1;
    endtask

    task automatic finish_frame();
        int n;
        logic [7:0] got;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk_25mhz);
            n++;
        end
        check("back_to_hunt", busy, 0);
        check("wr_count", wr_cnt, exp_wr);
        if (exp_wr > 0) begin
            check("wr_addr", wr_addr_seen, exp_addr);
            check("wr_data", wr_data_seen, exp_data);
        end
        check("rd_cycles", rd_cycles, exp_rd);
        check("frame_err_count", err_cnt, exp_err);
        check("tx_len", txq.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
            got = (i < txq.size()) ? txq[i] : 8'hxx;
            check("tx_byte_seq", got, exp_tx[i]);
        end
        @(posedge clk_25mhz); #1;
    endtask

    task automatic pulse_reset();
        core_reset = 1'b1;
        idle(1);
        core_reset = 1'b0;
    endtask

    initial begin : main
        logic [7:0]  cmd, addr;
        logic [31:0] data;
        int r;
        core_reset = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        rd_lat = 0;
        rd_value = 32'h0;
        ready_mode = 0;
        bp_left = 0;
        wr_addr_seen = 8'h00;
        wr_data_seen = 32'h0;
        clear_obs();
        idle(3);
        @(negedge clk_25mhz);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_addr", u_reg_addr, 0);
        check("rst_wr_data", u_reg_wr_data, 0);
        check("rst_wr_en", u_reg_wr_en, 0);
        check("rst_rd_en", u_reg_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge clk_25mhz); #1;
        core_reset = 1'b0;
        idle(2);

        // Basic write.
        clear_obs();
        expect_frame(CMD_WR, 8'hA2, 32'hDEADBEEF, 0);
        send_frame(0, CMD_WR, 8'hA2, 32'hDEADBEEF, 1'b0);
        finish_frame();

        // Basic read, done one cycle after rd_en.
        clear_obs();
        rd_lat = 1; rd_value = 32'hAAAADDDD;
        expect_frame(CMD_RD, 8'h10, 32'h0, rd_lat);
        send_frame(0, CMD_RD, 8'h10, 32'h0, 1'b0);
        finish_frame();

        // Junk before MAGIC, then an unknown command.
        clear_obs();
        expect_frame(8'h07, 8'h01, 32'h0, 0);
        send_byte(8'h55);
        send_byte(8'h00);
        send_frame(0, 8'h07, 8'h01, 32'h0, 1'b0);
        finish_frame();

        // Transmitter stalls five cycles in the middle of a read response.
        clear_obs();
        ready_mode = 2; bp_left = 5;
        rd_lat = 1; rd_value = 32'hAAAADDDD;
        expect_frame(CMD_RD, 8'h33, 32'h12345678, rd_lat);
        send_frame(0, CMD_RD, 8'h33, 32'h12345678, 1'b0);
        finish_frame();
        ready_mode = 0;

        // Byte arriving while the response is stalled is dropped, not queued.
        clear_obs();
        ready_mode = 3;
        expect_frame(CMD_WR, 8'h44, 32'h0BADF00D, 0);
        send_frame(0, CMD_WR, 8'h44, 32'h0BADF00D, 1'b0);
        idle(3);
        send_byte(MAGIC);
        exp_err = 1;
        ready_mode = 0;
        finish_frame();
        idle(4);
        @(negedge clk_25mhz);
        check("dropped_not_queued", busy, 0);
        @(posedge clk_25mhz); #1;

        // Done arriving in the last allowed cycle still yields a normal read.
        clear_obs();
        rd_lat = TMO - 1; rd_value = 32'hC0DE5EED;
        expect_frame(CMD_RD, 8'h20, 32'h0, rd_lat);
        send_frame(0, CMD_RD, 8'h20, 32'h0, 1'b0);
        finish_frame();

        // Read that never completes.
        clear_obs();
        rd_lat = -1;
        expect_frame(CMD_RD, 8'h21, 32'h0, rd_lat);
        send_frame(0, CMD_RD, 8'h21, 32'h0, 1'b0);
        if (TMO_EN) begin
            finish_frame();
        end else begin
            idle(100);
            @(negedge clk_25mhz);
            check("no_tmo_busy", busy, 1);
            check("no_tmo_rd_en", u_reg_rd_en, 1);
            check("no_tmo_tx", txq.size(), 0);
            @(posedge clk_25mhz); #1;
            pulse_reset();
        end

        // Reset in the middle of a read: rd_en drops, nothing is sent.
        clear_obs();
        rd_lat = -1;
        expect_frame(CMD_RD, 8'h22, 32'h0, rd_lat);
        send_frame(0, CMD_RD, 8'h22, 32'h0, 1'b0);
        idle(2);
        pulse_reset();
        @(negedge clk_25mhz);
        check("rst_read_rd_en", u_reg_rd_en, 0);
        check("rst_read_busy", busy, 0);
        @(posedge clk_25mhz); #1;
        idle(4);
        check("rst_read_no_tx", txq.size(), 0);

        // Reset after four bytes of a frame, then a clean write.
        clear_obs();
        send_byte(MAGIC); send_byte(CMD_WR); send_byte(8'hA2); send_byte(8'hDE);
        pulse_reset();
        @(negedge clk_25mhz);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_addr", u_reg_addr, 0);
        check("rst_mid_data", u_reg_wr_data, 0);
        @(posedge clk_25mhz); #1;
        clear_obs();
        expect_frame(CMD_WR, 8'h5A, 32'h01234567, 0);
        send_frame(0, CMD_WR, 8'h5A, 32'h01234567, 1'b0);
        finish_frame();

        // Randomized frames.
        for (int t = 0; t < 25; t++) begin
            clear_obs();
            r = $urandom_range(0, 9);
            if (r < 4) cmd = CMD_WR;
            else if (r < 8) cmd = CMD_RD;
            else begin
                cmd = 8'($urandom);
                if (cmd == CMD_WR || cmd == CMD_RD) cmd = cmd ^ 8'h01;
            end
            addr = 8'($urandom);
            data = $urandom;
            rd_lat = $urandom_range(0, 4);
            rd_value = $urandom;
            ready_mode = $urandom_range(0, 1);
            expect_frame(cmd, addr, data, rd_lat);
            send_frame($urandom_range(0, 2), cmd, addr, data, 1'b1);
            finish_frame();
        end
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
